// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory bus slave backed by a word-organised on-chip RAM
module dmem_responder #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dmem_req,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  logic            dmem_we,
    input  logic [1:0]      dmem_size,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            dmem_misaligned,
    output logic            dmem_page_fault,
    output logic            busy
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HWORD = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [3:0] WS_LAST  = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, nxt;
    logic [3:0]      cnt;
    logic [XLEN-1:0] r_adr, r_d;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_load;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem [DEPTH];

    // In IDLE the live bus is decoded so a zero-wait transfer can respond on the next edge.
    logic [XLEN-1:0] sel_adr, off;
    logic [1:0]      sel_size;
    logic            sel_we, cls_mis, cls_err;
    logic [AW-1:0]   idx;
    logic [3:0]      be;

    always_comb begin
        sel_adr  = (state == S_IDLE) ? dmem_adr  : r_adr;
        sel_size = (state == S_IDLE) ? dmem_size : r_size;
        sel_we   = (state == S_IDLE) ? dmem_we   : r_we;
        off      = sel_adr - BASE_ADDR;
        idx      = off[AW+1:2];
        cls_mis  = ((sel_size == SZ_HWORD) && off[0]) ||
                   ((sel_size == SZ_WORD) && (off[1:0] != 2'b00));
        cls_err  = (sel_size > SZ_WORD) || (off[XLEN-1:AW+2] != '0);
        case (sel_size)
            SZ_BYTE:  be = 4'b0001 << off[1:0];
            SZ_HWORD: be = 4'b0011 << off[1:0];
            default:  be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (dmem_req) nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (cnt == WS_LAST) nxt = S_RESP;
            S_RESP: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                  cnt <= 4'd0;
        else if (state == S_WAIT) cnt <= cnt + 4'd1;
        else                      cnt <= 4'd0;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && dmem_req) begin
            r_adr  <= dmem_adr;
            r_d    <= dmem_d;
            r_we   <= dmem_we;
            r_size <= dmem_size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_ack        <= 1'b0;
            dmem_err        <= 1'b0;
            dmem_misaligned <= 1'b0;
            r_load          <= 1'b0;
        end else if (nxt == S_RESP) begin
            dmem_misaligned <= cls_mis;
            dmem_err        <= !cls_mis && cls_err;
            dmem_ack        <= !cls_mis && !cls_err;
            r_load          <= !sel_we;
        end else begin
            dmem_ack        <= 1'b0;
            dmem_err        <= 1'b0;
            dmem_misaligned <= 1'b0;
            r_load          <= 1'b0;
        end
    end

    // Read every cycle; only the read on the edge into RESP is ever presented.
    always_ff @(posedge clk) begin
        rd_data <= mem[idx];
        if (!rst && state == S_RESP && r_we && dmem_ack) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= r_d[8*k +: 8];
            end
        end
    end

    assign dmem_q          = (dmem_ack && r_load) ? rd_data : '0;
    assign dmem_page_fault = 1'b0;
    assign busy            = (state != S_IDLE);

endmodule
